// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants for the mux8 round-robin arbiter: requester count,
// select width, state encoding and a one-hot helper.
package mux8_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational rotating-priority encoder: first set REQ bit at or above PTR,
// searching upward and wrapping 7->0.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] REQ,
    input  logic [SEL_W-1:0] PTR,
    output logic             VALID,
    output logic [SEL_W-1:0] IDX
);

    // rot[k] is the request that sits k places after PTR
    logic [N_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = REQ[PTR + SEL_W'(gi)];
        end
    endgenerate

    // Scan from the far end so the closest set bit to PTR wins.
    always_comb begin
        VALID = 1'b0;
        IDX   = PTR;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                VALID = 1'b1;
                IDX   = PTR + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbitration for a shared 8:1 data mux; the grant is held
// until the owner finishes, withdraws, or the hold limit expires.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [SEL_W-1:0] SEL,
    output logic [N_REQ-1:0] GNT,
    output logic             BUSY,
    output logic             TIMEOUT
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] CNT_SAT   = '1;
    localparam logic              HOLD_ON   = (MAX_HOLD != 0);

    logic              state_reg,   state_next;
    logic [SEL_W-1:0]  sel_reg,     sel_next;
    logic [N_REQ-1:0]  gnt_reg,     gnt_next;
    logic              busy_reg,    busy_next;
    logic              timeout_reg, timeout_next;
    logic [SEL_W-1:0]  ptr_reg,     ptr_next;
    logic [HOLD_W-1:0] cnt_reg,     cnt_next;

    logic              idle_valid;
    logic [SEL_W-1:0]  idle_idx;
    logic              hand_valid;
    logic [SEL_W-1:0]  hand_idx;
    logic [SEL_W-1:0]  hand_ptr;

    logic              rel_done;
    logic              rel_withdraw;
    logic              rel_hold;
    logic              release_now;

    // Handover search starts just past the owner, so the owner comes last.
    assign hand_ptr = sel_reg + SEL_W'(1);

    rr_pick8 u_pick_idle (
        .REQ   (REQ),
        .PTR   (ptr_reg),
        .VALID (idle_valid),
        .IDX   (idle_idx)
    );

    rr_pick8 u_pick_hand (
        .REQ   (REQ),
        .PTR   (hand_ptr),
        .VALID (hand_valid),
        .IDX   (hand_idx)
    );

    assign rel_done     = DONE;
    assign rel_withdraw = ~REQ[sel_reg];
    assign rel_hold     = HOLD_ON && (cnt_reg == HOLD_LAST);
    assign release_now  = rel_done | rel_withdraw | rel_hold;

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        gnt_next     = gnt_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (idle_valid) begin
                    state_next = ST_OWN;
                    sel_next   = idle_idx;
                    gnt_next   = onehot(idle_idx);
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (release_now) begin
                    ptr_next     = hand_ptr;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_next = rel_hold & ~rel_done & ~rel_withdraw;
                    cnt_next     = '0;
                    if (hand_valid) begin
                        sel_next = hand_idx;
                        gnt_next = onehot(hand_idx);
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = '0;
                        busy_next  = 1'b0;
                    end
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            gnt_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            gnt_reg     <= gnt_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign SEL     = sel_reg;
    assign GNT     = gnt_reg;
    assign BUSY    = busy_reg;
    assign TIMEOUT = timeout_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus a randomized
// run compared against an owner/pointer reference model.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] REQ = 8'h00;
    logic       DONE = 1'b0;
    logic [2:0] SEL;
    logic [7:0] GNT;
    logic       BUSY;
    logic       TIMEOUT;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, where the next search starts,
    // how long the owner has held it, and whether a timeout was just reported.
    int m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_held = 0;
    int m_to   = 0;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DONE    (DONE),
        .SEL     (SEL),
        .GNT     (GNT),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    function automatic int find_winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        logic [7:0] g;
        g = 8'h00;
        if (m_busy != 0) g[m_sel] = 1'b1;
        return g;
    endfunction

    task automatic model_update(input logic [7:0] r, input logic d, input logic rs);
        int  w;
        bit  by_done, by_withdraw, by_limit;
        if (rs) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_busy == 0) begin
            m_to = 0;
            w = find_winner(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_held = 0;
            end
        end else begin
            by_done     = d;
            by_withdraw = !r[m_sel];
            by_limit    = (MAX_HOLD != 0) && (m_held + 1 >= MAX_HOLD);
            if (by_done || by_withdraw || by_limit) begin
                m_to  = (by_limit && !by_done && !by_withdraw) ? 1 : 0;
                m_ptr = (m_sel + 1) % 8;
                w = find_winner(r, m_ptr);
                m_held = 0;
                if (w >= 0) m_sel = w;
                else m_busy = 0;
            end else begin
                m_to = 0;
                m_held = m_held + 1;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic cycle(input logic [7:0] r, input logic d, input logic rs);
        REQ = r; DONE = d; RST = rs;
        @(posedge CLK);
        model_update(r, d, rs);
        #1;
    endtask

    task automatic test_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(8'h00, 1'b0, 1'b0);
            total++;
            if (GNT !== 8'h00 || BUSY !== 1'b0 || SEL !== 3'd0 || TIMEOUT !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got gnt=%h busy=%b sel=%0d to=%b want 00/0/0/0",
                         i, GNT, BUSY, SEL, TIMEOUT);
            end
        end
        $display("test_reset: 5 idle cycles checked");
    endtask

    task automatic test_handover();
        cycle(8'h24, 1'b0, 1'b0);
        total++;
        if (GNT !== 8'h04 || SEL !== 3'd2 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL first_grant got gnt=%h sel=%0d busy=%b want 04/2/1", GNT, SEL, BUSY);
        end
        cycle(8'h24, 1'b1, 1'b0);
        total++;
        if (GNT !== 8'h20 || SEL !== 3'd5 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL handover got gnt=%h sel=%0d busy=%b want 20/5/1", GNT, SEL, BUSY);
        end
        cycle(8'h00, 1'b1, 1'b0);
        total++;
        if (GNT !== 8'h00 || BUSY !== 1'b0 || SEL !== 3'd5) begin
            bad++;
            $display("FAIL release_idle got gnt=%h busy=%b sel=%0d want 00/0/5", GNT, BUSY, SEL);
        end
        $display("test_handover: gnt 04 -> 20 -> idle");
    endtask

    task automatic test_rotation();
        int seen [8];
        int want;
        foreach (seen[i]) seen[i] = 0;
        cycle(8'hFF, 1'b0, 1'b1);
        cycle(8'hFF, 1'b0, 1'b0);
        total++;
        if (SEL !== 3'd0 || GNT !== 8'h01) begin
            bad++;
            $display("FAIL rot_start got sel=%0d gnt=%h want 0/01", SEL, GNT);
        end
        seen[0]++;
        for (int k = 1; k <= 8; k++) begin
            cycle(8'hFF, 1'b1, 1'b0);
            want = k % 8;
            total++;
            if (SEL !== 3'(want) || GNT !== 8'(1 << want) || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL rot_step k=%0d got sel=%0d gnt=%h busy=%b want sel=%0d",
                         k, SEL, GNT, BUSY, want);
            end
            if (k < 8) seen[int'(SEL)]++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seen[i] != 1) begin
                bad++;
                $display("FAIL rot_fair req=%0d got %0d grants want 1", i, seen[i]);
            end
        end
        $display("test_rotation: 9 grants through all requesters");
    endtask

    task automatic test_timeout();
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < MAX_HOLD; i++) begin
            cycle(8'h01, 1'b0, 1'b0);
            total++;
            if (GNT !== 8'h01 || TIMEOUT !== 1'b0) begin
                bad++;
                $display("FAIL hold cyc=%0d got gnt=%h to=%b want 01/0", i, GNT, TIMEOUT);
            end
        end
        cycle(8'h01, 1'b0, 1'b0);
        total++;
        if (TIMEOUT !== 1'b1 || GNT !== 8'h01 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse got to=%b gnt=%h busy=%b want 1/01/1", TIMEOUT, GNT, BUSY);
        end
        cycle(8'h01, 1'b1, 1'b0);
        total++;
        if (TIMEOUT !== 1'b0 || GNT !== 8'h01) begin
            bad++;
            $display("FAIL timeout_end got to=%b gnt=%h want 0/01", TIMEOUT, GNT);
        end
        // Regrant restarted the hold count: limit and DONE coincide here, so no pulse.
        for (int i = 0; i < MAX_HOLD - 1; i++) cycle(8'h01, 1'b0, 1'b0);
        cycle(8'h01, 1'b1, 1'b0);
        total++;
        if (TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL timeout_masked got to=%b want 0", TIMEOUT);
        end
        $display("test_timeout: 16-cycle hold then one-cycle pulse");
    endtask

    task automatic test_withdraw();
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h48, 1'b0, 1'b0);
        cycle(8'h48, 1'b0, 1'b0);
        total++;
        if (GNT !== 8'h08 || SEL !== 3'd3) begin
            bad++;
            $display("FAIL withdraw_owner got gnt=%h sel=%0d want 08/3", GNT, SEL);
        end
        cycle(8'h40, 1'b0, 1'b0);
        total++;
        if (GNT !== 8'h40 || SEL !== 3'd6 || TIMEOUT !== 1'b0 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL withdraw_next got gnt=%h sel=%0d to=%b busy=%b want 40/6/0/1",
                     GNT, SEL, TIMEOUT, BUSY);
        end
        $display("test_withdraw: owner 3 drops, owner 6 takes over");
    endtask

    task automatic test_reset_midgrant();
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h10, 1'b0, 1'b0);
        cycle(8'h11, 1'b1, 1'b0);
        cycle(8'h11, 1'b1, 1'b0);
        total++;
        if (GNT !== 8'h10) begin
            bad++;
            $display("FAIL pre_reset got gnt=%h want 10", GNT);
        end
        cycle(8'h10, 1'b0, 1'b1);
        total++;
        if (GNT !== 8'h00 || BUSY !== 1'b0 || SEL !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid got gnt=%h busy=%b sel=%0d want 00/0/0", GNT, BUSY, SEL);
        end
        cycle(8'h10, 1'b0, 1'b0);
        total++;
        if (GNT !== 8'h10 || SEL !== 3'd4) begin
            bad++;
            $display("FAIL post_reset got gnt=%h sel=%0d want 10/4", GNT, SEL);
        end
        // With the pointer back at 0, requester 0 beats requester 4.
        cycle(8'h11, 1'b0, 1'b1);
        cycle(8'h11, 1'b0, 1'b0);
        total++;
        if (GNT !== 8'h01 || SEL !== 3'd0) begin
            bad++;
            $display("FAIL ptr_restart got gnt=%h sel=%0d want 01/0", GNT, SEL);
        end
        $display("test_reset_midgrant: reset drops grant, pointer restarts");
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       d, rs;
        logic [7:0] eg;
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            r  = 8'($urandom) & 8'($urandom | 32'h0000_0055);
            d  = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 63) == 0);
            cycle(r, d, rs);
            eg = exp_gnt();
            total++;
            if (GNT !== eg || BUSY !== 1'(m_busy) || TIMEOUT !== 1'(m_to) ||
                SEL !== 3'(m_sel)) begin
                bad++;
                $display("FAIL random cyc=%0d got gnt=%h sel=%0d busy=%b to=%b want gnt=%h sel=%0d busy=%0d to=%0d",
                         i, GNT, SEL, BUSY, TIMEOUT, eg, m_sel, m_busy, m_to);
            end
            $display("rand %0d req=%h done=%b rst=%b -> gnt=%h sel=%0d busy=%b to=%b",
                     i, r, d, rs, GNT, SEL, BUSY, TIMEOUT);
        end
    endtask

    initial begin
        test_reset();
        test_handover();
        test_rotation();
        test_timeout();
        test_withdraw();
        test_reset_midgrant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
